alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Execution stage that sits directly upstream of the parameterised ALU and also consumes its outputs.
- Accepts one instruction at a time over a valid/ready handshake.
- Reads the two source operands from an internal register file (or substitutes an immediate for B), drives the ALU's A/B/op inputs, and captures Y and ONZ.
- Writes Y back to the destination register and updates a persistent flag register.

Parameters:
- WIDTH, 8, data width; must equal the ALU width parameter.
- NREGS, 8, register count; power of two, at least 2.
- AW, $clog2(NREGS), register address width (derived; not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  unit can accept an instruction.
- instr_op  in  3  ALU opcode; passed through unchanged.
- instr_rd  in  AW  destination register.
- instr_ra  in  AW  source register for A.
- instr_rb  in  AW  source register for B.
- instr_imm_en  in  1  when 1, B = instr_imm instead of R[rb].
- instr_imm  in  WIDTH  immediate operand.
- alu_a  out  WIDTH  to ALU A.
- alu_b  out  WIDTH  to ALU B.
- alu_op  out  3  to ALU op.
- alu_y  in  WIDTH  from ALU Y.
- alu_onz  in  3  from ALU ONZ; bit2 = O, bit1 = N, bit0 = Z.
- flags  out  3  registered ONZ of the last completed instruction.
- done  out  1  one-cycle pulse; high during the write-back cycle.
- dbg_addr  in  AW  debug read address.
- dbg_data  out  WIDTH  combinational R[dbg_addr].

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - state = IDLE; all registers, operand latches, result latch and flags = 0; alu_op latch = 0.
  - done = 0; instr_ready = 1 once rst_n is released.
  - Reset in any state aborts the in-flight instruction: no write-back, no flag update, no done pulse.
- States:
  - IDLE: instr_ready = 1. On instr_valid & instr_ready at edge T, latch op and rd, and latch opA = R[ra] and opB = (imm_en ? imm : R[rb]). Go to EXEC.
  - EXEC (cycle after T): instr_ready = 0. alu_a/alu_b/alu_op are driven from the latches. At edge T+1, capture alu_y into res and alu_onz into onz_lat. Go to WB.
  - WB: instr_ready = 0 and done = 1. At edge T+2: R[rd] <= res (suppressed when rd = 0); flags <= onz_lat (always, including when rd = 0). Go to IDLE.
- Throughput and latency:
  - One instruction per 3 cycles.
  - Result becomes visible on dbg_data and flags in the cycle after done.
- ALU drive outside EXEC:
  - alu_a/alu_b/alu_op are always driven from the latches, so they are stable outside EXEC.
  - The ALU output is sampled only at the end of EXEC.
- R0 is hardwired to 0: reads return 0, writes are ignored.
- No hazards by construction: write-back completes before the next accept, so a back-to-back read of the just-written register returns the new value with no bypass path.
- instr_valid while instr_ready = 0 is ignored. The producer holds its instruction until the handshake occurs; the unit never samples the instruction fields outside IDLE.
- Opcodes are opaque to the unit and forwarded unchanged. All 8 codes are legal.

Decomposition:
- Package alu_pkg holds:
  - opcode constants, OP_ADD = 3'd0 and OP_SUB = 3'd1 (the remaining codes follow the ALU definition);
  - flag bit indices FLAG_O = 2, FLAG_N = 1, FLAG_Z = 0;
  - the state enum {IDLE, EXEC, WB}.
- One sub-module, reg_file: NREGS x WIDTH, two combinational read ports plus the debug read port, one synchronous write port, R0 hardwired to 0, same asynchronous active-low reset.
- The bench instantiates the real ALU and connects it to alu_* ports.

Test Plan (WIDTH = 8, real ALU attached):
1. ADD r1 = r0 + imm 0x7F, then ADD r2 = r1 + imm 0x01 -> R1 = 0x7F with flags 3'b000; R2 = 0x80 with flags 3'b110 (O = 1, N = 1, Z = 0); done pulses once per instruction, each 2 cycles after its accept edge.
2. SUB r3 = r2 - r2 (rb = r2, imm_en = 0) -> R3 = 0x00, flags 3'b001.
3. ADD r0 = r0 + imm 0x05 -> dbg_data at address 0 stays 0x00; flags = 3'b000 (updated even though the write is suppressed).
4. Hold instr_valid = 1 for 9 cycles with changing fields -> instr_ready pattern 1,0,0 repeating; exactly 3 instructions accepted, namely those present at the IDLE edges.
5. Write R4 = 0x2A, then an instruction with ra = r4 accepted in the first IDLE cycle after done -> alu_a = 0x2A during EXEC.
6. Assert rst_n = 0 during EXEC of ADD r5 = r0 + imm 0x10 -> R5 = 0x00, flags = 3'b000, no done pulse, instr_ready = 1 after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the execution stage and the ALU it drives:
// opcode constants, ONZ flag bit positions and the execution FSM states.
package alu_pkg;

   // Opcodes are opaque to the execution unit; only the ALU decodes them.
   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_AND  = 3'd2;
   localparam logic [2:0] OP_OR   = 3'd3;
   localparam logic [2:0] OP_XOR  = 3'd4;
   localparam logic [2:0] OP_SHL  = 3'd5;
   localparam logic [2:0] OP_SHR  = 3'd6;
   localparam logic [2:0] OP_PASB = 3'd7;

   // Bit positions inside the 3-bit ONZ flag vector.
   localparam int FLAG_O = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_Z = 0;

   // Execution FSM: accept, let the ALU settle, then write back.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } state_t;

endpackage

// File: rtl/alu.sv
// Parameterised combinational ALU. Produces the result Y and the ONZ flags:
// O is signed overflow (add/sub only), N is the result MSB, Z is result == 0.
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] y,
   output logic [2:0]       onz
);

   logic overflow;

   // Decode the opcode into a result and compute the overflow for add/sub.
   always_comb begin
      y        = '0;
      overflow = 1'b0;
      case (op)
         OP_ADD: begin
            y        = a + b;
            overflow = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            y        = a - b;
            overflow = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_SHL:  y = a << b;
         OP_SHR:  y = a >> b;
         OP_PASB: y = b;
         default: y = '0;
      endcase
   end

   // Pack overflow, sign and zero into the ONZ vector.
   always_comb begin
      onz         = '0;
      onz[FLAG_O] = overflow;
      onz[FLAG_N] = y[WIDTH-1];
      onz[FLAG_Z] = (y == '0);
   end

endmodule

// File: rtl/reg_file.sv
// NREGS x WIDTH register file: two combinational operand read ports, one
// combinational debug read port and one synchronous write port. R0 always
// reads as zero and is never written.
module reg_file #(
   parameter int WIDTH = 8,
   parameter int NREGS = 8,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [AW-1:0]    raAddr_i,
   output logic [WIDTH-1:0] raData_o,
   input  logic [AW-1:0]    rbAddr_i,
   output logic [WIDTH-1:0] rbData_o,
   input  logic [AW-1:0]    dbgAddr_i,
   output logic [WIDTH-1:0] dbgData_o,
   input  logic             wrEn_i,
   input  logic [AW-1:0]    wrAddr_i,
   input  logic [WIDTH-1:0] wrData_i
);

   logic [WIDTH-1:0] regs_q [NREGS];

   // Storage: cleared on reset, written on the rising edge; R0 writes are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wrEn_i && (wrAddr_i != '0)) begin
         regs_q[wrAddr_i] <= wrData_i;
      end
   end

   assign raData_o  = (raAddr_i  == '0) ? '0 : regs_q[raAddr_i];
   assign rbData_o  = (rbAddr_i  == '0) ? '0 : regs_q[rbAddr_i];
   assign dbgData_o = (dbgAddr_i == '0) ? '0 : regs_q[dbgAddr_i];

endmodule

// File: rtl/alu_exec_unit.sv
// Execution stage wrapped around an external ALU. Accepts one instruction per
// three cycles: operands are latched on accept, the ALU result is captured at
// the end of EXEC, and write-back plus flag update happen at the end of WB.
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NREGS = 8,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [2:0]       instr_op,
   input  logic [AW-1:0]    instr_rd,
   input  logic [AW-1:0]    instr_ra,
   input  logic [AW-1:0]    instr_rb,
   input  logic             instr_imm_en,
   input  logic [WIDTH-1:0] instr_imm,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_op,
   input  logic [WIDTH-1:0] alu_y,
   input  logic [2:0]       alu_onz,
   output logic [2:0]       flags,
   output logic             done,
   input  logic [AW-1:0]    dbg_addr,
   output logic [WIDTH-1:0] dbg_data
);

   state_t           state_q;
   logic [WIDTH-1:0] opA_q;
   logic [WIDTH-1:0] opB_q;
   logic [2:0]       op_q;
   logic [AW-1:0]    rd_q;
   logic [WIDTH-1:0] res_q;
   logic [2:0]       onz_q;
   logic [2:0]       flags_q;

   logic [WIDTH-1:0] raData;
   logic [WIDTH-1:0] rbData;
   logic             wrEn;

   // Write-back happens only in WB; an aborted instruction never reaches it.
   assign wrEn = (state_q == WB);

   reg_file #(
      .WIDTH (WIDTH),
      .NREGS (NREGS)
   ) u_reg_file (
      .clk       (clk),
      .rst_n     (rst_n),
      .raAddr_i  (instr_ra),
      .raData_o  (raData),
      .rbAddr_i  (instr_rb),
      .rbData_o  (rbData),
      .dbgAddr_i (dbg_addr),
      .dbgData_o (dbg_data),
      .wrEn_i    (wrEn),
      .wrAddr_i  (rd_q),
      .wrData_i  (res_q)
   );

   // Sequencer: latch operands on accept, capture the ALU in EXEC, retire in WB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         opA_q   <= '0;
         opB_q   <= '0;
         op_q    <= '0;
         rd_q    <= '0;
         res_q   <= '0;
         onz_q   <= '0;
         flags_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (instr_valid) begin
                  op_q    <= instr_op;
                  rd_q    <= instr_rd;
                  opA_q   <= raData;
                  opB_q   <= instr_imm_en ? instr_imm : rbData;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               res_q   <= alu_y;
               onz_q   <= alu_onz;
               state_q <= WB;
            end
            WB: begin
               flags_q <= onz_q;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign instr_ready = (state_q == IDLE);
   assign done        = (state_q == WB);
   assign alu_a       = opA_q;
   assign alu_b       = opB_q;
   assign alu_op      = op_q;
   assign flags       = flags_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit with the real ALU attached. Inputs change
// just after the rising edge; outputs are sampled on the falling edge.
module tb_alu_exec_unit;
   import alu_pkg::*;

   localparam int WIDTH = 8;
   localparam int NREGS = 8;
   localparam int AW    = 3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             instr_valid;
   logic             instr_ready;
   logic [2:0]       instr_op;
   logic [AW-1:0]    instr_rd;
   logic [AW-1:0]    instr_ra;
   logic [AW-1:0]    instr_rb;
   logic             instr_imm_en;
   logic [WIDTH-1:0] instr_imm;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [2:0]       alu_op;
   logic [WIDTH-1:0] alu_y;
   logic [2:0]       alu_onz;
   logic [2:0]       flags;
   logic             done;
   logic [AW-1:0]    dbg_addr;
   logic [WIDTH-1:0] dbg_data;

   int checks    = 0;
   int errors    = 0;
   int doneCount = 0;

   alu_exec_unit #(
      .WIDTH (WIDTH),
      .NREGS (NREGS)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .instr_op     (instr_op),
      .instr_rd     (instr_rd),
      .instr_ra     (instr_ra),
      .instr_rb     (instr_rb),
      .instr_imm_en (instr_imm_en),
      .instr_imm    (instr_imm),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_op       (alu_op),
      .alu_y        (alu_y),
      .alu_onz      (alu_onz),
      .flags        (flags),
      .done         (done),
      .dbg_addr     (dbg_addr),
      .dbg_data     (dbg_data)
   );

   alu #(
      .WIDTH (WIDTH)
   ) u_alu (
      .a   (alu_a),
      .b   (alu_b),
      .op  (alu_op),
      .y   (alu_y),
      .onz (alu_onz)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Count every cycle in which done is high, sampled mid-cycle.
   always @(negedge clk) begin
      if (done) doneCount++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic readReg(input logic [AW-1:0] addr, output logic [WIDTH-1:0] data);
      dbg_addr = addr;
      #1;
      data = dbg_data;
   endtask

   // Issue one instruction from a falling edge in IDLE and follow it through
   // EXEC and WB, checking handshake, ALU drive, done timing and the result.
   task automatic applyStimulus(input string tag, input logic [2:0] op,
                                input logic [AW-1:0] rd, input logic [AW-1:0] ra,
                                input logic [AW-1:0] rb, input logic immEn,
                                input logic [WIDTH-1:0] imm, input logic [WIDTH-1:0] expA,
                                input logic [WIDTH-1:0] expRd, input logic [2:0] expFlags);
      logic [WIDTH-1:0] value;
      checkOutput({tag, ".readyIdle"}, 32'(instr_ready), 32'd1);
      instr_op     = op;
      instr_rd     = rd;
      instr_ra     = ra;
      instr_rb     = rb;
      instr_imm_en = immEn;
      instr_imm    = imm;
      instr_valid  = 1'b1;
      @(posedge clk);
      #1 instr_valid = 1'b0;
      @(negedge clk);
      checkOutput({tag, ".readyExec"}, 32'(instr_ready), 32'd0);
      checkOutput({tag, ".doneExec"}, 32'(done), 32'd0);
      checkOutput({tag, ".aluA"}, 32'(alu_a), 32'(expA));
      checkOutput({tag, ".aluOp"}, 32'(alu_op), 32'(op));
      @(negedge clk);
      checkOutput({tag, ".doneWb"}, 32'(done), 32'd1);
      checkOutput({tag, ".readyWb"}, 32'(instr_ready), 32'd0);
      @(negedge clk);
      checkOutput({tag, ".doneAfter"}, 32'(done), 32'd0);
      checkOutput({tag, ".flags"}, 32'(flags), 32'(expFlags));
      readReg(rd, value);
      checkOutput({tag, ".rd"}, 32'(value), 32'(expRd));
   endtask

   initial begin
      logic [WIDTH-1:0] value;
      int               doneBefore;

      rst_n        = 1'b0;
      instr_valid  = 1'b0;
      instr_op     = '0;
      instr_rd     = '0;
      instr_ra     = '0;
      instr_rb     = '0;
      instr_imm_en = 1'b0;
      instr_imm    = '0;
      dbg_addr     = '0;

      // Reset state.
      repeat (2) @(negedge clk);
      checkOutput("rst.doneLow", 32'(done), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("rst.ready", 32'(instr_ready), 32'd1);
      checkOutput("rst.done", 32'(done), 32'd0);
      checkOutput("rst.flags", 32'(flags), 32'd0);
      checkOutput("rst.aluA", 32'(alu_a), 32'd0);
      checkOutput("rst.aluOp", 32'(alu_op), 32'd0);
      readReg(3'd1, value);
      checkOutput("rst.r1", 32'(value), 32'd0);

      // Signed overflow boundary on add.
      applyStimulus("add1", OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 8'h7F, 8'h00, 8'h7F, 3'b000);
      applyStimulus("add2", OP_ADD, 3'd2, 3'd1, 3'd0, 1'b1, 8'h01, 8'h7F, 8'h80, 3'b110);

      // Register-register subtract giving zero.
      applyStimulus("sub3", OP_SUB, 3'd3, 3'd2, 3'd2, 1'b0, 8'h00, 8'h80, 8'h00, 3'b001);

      // Write to R0 is dropped but the flags still update.
      applyStimulus("addR0", OP_ADD, 3'd0, 3'd0, 3'd0, 1'b1, 8'h05, 8'h00, 8'h00, 3'b000);

      // Hold valid for nine cycles; only the fields present in IDLE are taken.
      doneBefore = doneCount;
      for (int i = 0; i < 9; i++) begin
         checkOutput($sformatf("hold.ready%0d", i), 32'(instr_ready),
                     (i % 3 == 0) ? 32'd1 : 32'd0);
         instr_valid  = 1'b1;
         instr_op     = OP_ADD;
         instr_rd     = AW'(i + 1);
         instr_ra     = 3'd0;
         instr_rb     = 3'd0;
         instr_imm_en = 1'b1;
         instr_imm    = WIDTH'(8'h10 + i);
         @(negedge clk);
      end
      instr_valid = 1'b0;
      @(negedge clk);
      checkOutput("hold.doneCount", 32'(doneCount - doneBefore), 32'd3);
      readReg(3'd1, value);
      checkOutput("hold.r1", 32'(value), 32'h10);
      readReg(3'd4, value);
      checkOutput("hold.r4", 32'(value), 32'h13);
      readReg(3'd7, value);
      checkOutput("hold.r7", 32'(value), 32'h16);
      readReg(3'd2, value);
      checkOutput("hold.r2", 32'(value), 32'h80);
      readReg(3'd3, value);
      checkOutput("hold.r3", 32'(value), 32'h00);
      readReg(3'd5, value);
      checkOutput("hold.r5", 32'(value), 32'h00);

      // Back-to-back read of the just-written register.
      applyStimulus("wr4", OP_ADD, 3'd4, 3'd0, 3'd0, 1'b1, 8'h2A, 8'h00, 8'h2A, 3'b000);
      applyStimulus("use4", OP_SUB, 3'd6, 3'd4, 3'd0, 1'b1, 8'h2A, 8'h2A, 8'h00, 3'b001);

      // Reset during EXEC aborts the instruction.
      doneBefore   = doneCount;
      instr_op     = OP_ADD;
      instr_rd     = 3'd5;
      instr_ra     = 3'd0;
      instr_rb     = 3'd0;
      instr_imm_en = 1'b1;
      instr_imm    = 8'h10;
      instr_valid  = 1'b1;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      rst_n       = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("abort.doneCount", 32'(doneCount - doneBefore), 32'd0);
      checkOutput("abort.flags", 32'(flags), 32'd0);
      checkOutput("abort.ready", 32'(instr_ready), 32'd1);
      readReg(3'd5, value);
      checkOutput("abort.r5", 32'(value), 32'd0);
      readReg(3'd4, value);
      checkOutput("abort.r4", 32'(value), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
